// File: rtl/alu_issue_stage.sv
// Operand-fetch/issue and writeback stage in front of a combinational ALU.
// Optional build macro ALU_ISSUE_FWD_EN: forward alu_Y on RAW hazards instead of stalling.
module alu_issue_stage #(
    parameter int              N      = 16,
    parameter int              C      = 8,
    parameter int              S      = 5,
    parameter int              R      = 4,
    parameter logic [C-1:0]    NOP_OP = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [C-1:0] in_opcode,
    input  logic [R-1:0] in_rd,
    input  logic [R-1:0] in_rs,
    input  logic [R-1:0] in_rt,
    input  logic [N-1:0] in_imm,
    input  logic         in_use_imm,
    input  logic [S-1:0] in_shift,
    output logic [C-1:0] alu_opcode,
    output logic [N-1:0] alu_A,
    output logic [N-1:0] alu_B,
    output logic [S-1:0] alu_shift,
    input  logic [N-1:0] alu_Y,
    output logic         wb_valid,
    output logic [R-1:0] wb_rd,
    output logic [N-1:0] wb_data,
    input  logic [R-1:0] dbg_addr,
    output logic [N-1:0] dbg_data
);

    localparam int DEPTH = 1 << R;

    logic [N-1:0] rf [DEPTH];
    logic         e_valid;
    logic [R-1:0] e_rd;

    logic         accept;
    logic         e_writes;
    logic         hazard_rs;
    logic         hazard_rt;
    logic [N-1:0] rf_a;
    logic [N-1:0] rf_b;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;

    // r0 is hard-wired to zero on every read port, independent of storage contents.
    assign rf_a     = (in_rs == '0)    ? '0 : rf[in_rs];
    assign rf_b     = (in_rt == '0)    ? '0 : rf[in_rt];
    assign dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];

    assign e_writes  = e_valid && (e_rd != '0);
    assign hazard_rs = e_writes && (in_rs == e_rd);
    assign hazard_rt = e_writes && !in_use_imm && (in_rt == e_rd);
    assign accept    = in_valid && in_ready;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        op_a = rf_a;
        op_b = in_use_imm ? in_imm : rf_b;
`ifdef ALU_ISSUE_FWD_EN
        in_ready = 1'b1;
        if (hazard_rs) op_a = alu_Y;
        if (hazard_rt) op_b = alu_Y;
`else
        // One bubble lets the in-flight result land in the RF before the dependent read.
        in_ready = !(hazard_rs || hazard_rt);
`endif
    end

    // NOTE: the register file is flop-based and cleared by reset because software
    // relies on every register reading zero after reset; it is not a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= e_writes;
            if (e_writes) begin
                rf[e_rd] <= alu_Y;
                wb_rd    <= e_rd;
                wb_data  <= alu_Y;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_valid    <= 1'b0;
            e_rd       <= '0;
            alu_opcode <= NOP_OP;
            alu_A      <= '0;
            alu_B      <= '0;
            alu_shift  <= '0;
        end else begin
            e_valid <= accept;
            if (accept) begin
                e_rd       <= in_rd;
                alu_opcode <= in_opcode;
                alu_A      <= op_a;
                alu_B      <= op_b;
                alu_shift  <= in_shift;
            end else begin
                alu_opcode <= NOP_OP;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; the ALU is modelled as Y = A + B.
module tb_alu_issue_stage;

    localparam int N = 16;
    localparam int C = 8;
    localparam int S = 5;
    localparam int R = 4;
    localparam logic [C-1:0] NOP = 8'h00;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [C-1:0] in_opcode;
    logic [R-1:0] in_rd;
    logic [R-1:0] in_rs;
    logic [R-1:0] in_rt;
    logic [N-1:0] in_imm;
    logic         in_use_imm;
    logic [S-1:0] in_shift;
    logic [C-1:0] alu_opcode;
    logic [N-1:0] alu_A;
    logic [N-1:0] alu_B;
    logic [S-1:0] alu_shift;
    logic [N-1:0] alu_Y;
    logic         wb_valid;
    logic [R-1:0] wb_rd;
    logic [N-1:0] wb_data;
    logic [R-1:0] dbg_addr;
    logic [N-1:0] dbg_data;

    int checks = 0;
    int errors = 0;

    alu_issue_stage #(.N(N), .C(C), .S(S), .R(R), .NOP_OP(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
        .in_shift   (in_shift),
        .alu_opcode (alu_opcode),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_shift  (alu_shift),
        .alu_Y      (alu_Y),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    assign alu_Y = alu_A + alu_B;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge and return at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [C-1:0] op, input logic [R-1:0] rd, input logic [R-1:0] rs,
                         input logic [R-1:0] rt, input logic [N-1:0] imm, input logic use_imm);
        in_valid   = 1'b1;
        in_opcode  = op;
        in_rd      = rd;
        in_rs      = rs;
        in_rt      = rt;
        in_imm     = imm;
        in_use_imm = use_imm;
        in_shift   = 5'd3;
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        #1;
    endtask

    task automatic dbg_check(input string tag, input logic [R-1:0] addr, input logic [N-1:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, dbg_data, exp);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_opcode  = '0;
        in_rd      = '0;
        in_rs      = '0;
        in_rt      = '0;
        in_imm     = '0;
        in_use_imm = 1'b0;
        in_shift   = '0;
        dbg_addr   = '0;
        step();
        check("rst_wb_valid", wb_valid, 0);
        check("rst_opcode", alu_opcode, NOP);
        check("rst_alu_A", alu_A, 0);
        rst = 1'b0;
        step();

        // Reset mid-stream discards the in-flight instruction.
        issue(8'h11, 4'd1, 4'd0, 4'd0, 16'h0005, 1'b1);
        step();
        idle();
        check("mid_pre_B", alu_B, 16'h0005);
        check("mid_pre_opcode", alu_opcode, 8'h11);
        rst = 1'b1;
        #1;
        check("mid_opcode", alu_opcode, NOP);
        check("mid_alu_B", alu_B, 0);
        check("mid_alu_shift", alu_shift, 0);
        step();
        check("mid_wb_valid", wb_valid, 0);
        check("mid_wb_data", wb_data, 0);
        dbg_check("mid_rf1", 4'd1, 16'h0000);
        rst = 1'b0;
        step();

        // Immediate load with two-cycle latency to writeback.
        issue(8'h21, 4'd1, 4'd0, 4'd7, 16'h0005, 1'b1);
        check("imm_ready", in_ready, 1);
        step();
        idle();
        check("imm_alu_A", alu_A, 0);
        check("imm_alu_B", alu_B, 16'h0005);
        check("imm_opcode", alu_opcode, 8'h21);
        check("imm_shift", alu_shift, 5'd3);
        check("imm_wb_early", wb_valid, 0);
        step();
        check("imm_wb_valid", wb_valid, 1);
        check("imm_wb_rd", wb_rd, 1);
        check("imm_wb_data", wb_data, 16'h0005);
        check("imm_bubble_op", alu_opcode, NOP);
        check("imm_hold_B", alu_B, 16'h0005);
        dbg_check("imm_rf1", 4'd1, 16'h0005);
        step();
        check("imm_wb_drop", wb_valid, 0);
        check("imm_wb_hold", wb_data, 16'h0005);

        // Back-to-back dependent pair: r1 <- 3, r2 <- r1 + r1.
        issue(8'h31, 4'd1, 4'd0, 4'd0, 16'h0003, 1'b1);
        check("dep_ready0", in_ready, 1);
        step();
        issue(8'h32, 4'd2, 4'd1, 4'd1, 16'h0000, 1'b0);
`ifdef ALU_ISSUE_FWD_EN
        check("dep_fwd_ready", in_ready, 1);
        step();
        idle();
        check("dep_fwd_A", alu_A, 16'h0003);
        check("dep_fwd_B", alu_B, 16'h0003);
        check("dep_fwd_wb1", wb_data, 16'h0003);
        step();
`else
        check("dep_stall", in_ready, 0);
        step();
        check("dep_unstall", in_ready, 1);
        check("dep_wb1_valid", wb_valid, 1);
        check("dep_wb1_data", wb_data, 16'h0003);
        check("dep_bubble_op", alu_opcode, NOP);
        step();
        idle();
        check("dep_A", alu_A, 16'h0003);
        check("dep_B", alu_B, 16'h0003);
        step();
`endif
        check("dep_wb2_valid", wb_valid, 1);
        check("dep_wb2_rd", wb_rd, 2);
        check("dep_wb2_data", wb_data, 16'h0006);
        dbg_check("dep_rf2", 4'd2, 16'h0006);
        step();

        // Independent stream at full throughput.
        for (int i = 1; i <= 3; i++) begin
            issue(8'h40, R'(i), 4'd0, 4'd0, N'(i), 1'b1);
            check($sformatf("stream_ready%0d", i), in_ready, 1);
            step();
            if (i >= 2) begin
                check($sformatf("stream_wbv%0d", i - 1), wb_valid, 1);
                check($sformatf("stream_wbd%0d", i - 1), wb_data, i - 1);
            end
        end
        idle();
        step();
        check("stream_wbv3", wb_valid, 1);
        check("stream_wbr3", wb_rd, 3);
        check("stream_wbd3", wb_data, 3);
        step();
        check("stream_end", wb_valid, 0);

        // Writes to r0 are dropped and never cause a hazard.
        issue(8'h50, 4'd0, 4'd0, 4'd0, 16'h7FFF, 1'b1);
        step();
        issue(8'h51, 4'd1, 4'd0, 4'd0, 16'h0000, 1'b0);
        check("r0_no_stall", in_ready, 1);
        step();
        idle();
        check("r0_wb_none", wb_valid, 0);
        check("r0_alu_A", alu_A, 0);
        check("r0_alu_B", alu_B, 0);
        dbg_check("r0_rf0", 4'd0, 16'h0000);
        step();
        check("r0_wb1_valid", wb_valid, 1);
        check("r0_wb1_data", wb_data, 0);
        dbg_check("r0_rf1", 4'd1, 16'h0000);
        step();

        // Immediate operand masks a would-be rt hazard.
        issue(8'h60, 4'd4, 4'd0, 4'd0, 16'h0009, 1'b1);
        step();
        issue(8'h61, 4'd5, 4'd0, 4'd4, 16'h0002, 1'b1);
        check("imm_rt_ready", in_ready, 1);
        step();
        idle();
        check("imm_rt_B", alu_B, 16'h0002);
        check("imm_rt_wb4", wb_data, 16'h0009);
        step();
        check("imm_rt_wb5_rd", wb_rd, 5);
        check("imm_rt_wb5_data", wb_data, 16'h0002);
        dbg_check("imm_rt_rf5", 4'd5, 16'h0002);
        dbg_check("imm_rt_rf4", 4'd4, 16'h0009);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Operand-fetch/issue and writeback stage that feeds the combinational ALU. Holds a 2^R x N register file, accepts decoded instructions over a valid/ready handshake, and registers opcode/A/B/shift toward the ALU. Captures the ALU result Y one cycle later and writes it back to the register file. Detects read-after-write hazards against the in-flight instruction; stalls or forwards depending on build.

Parameters:
N, 16, operand/result width
C, 8, opcode width
S, 5, shift-amount width
R, 4, register address width (2^R registers)
NOP_OP, 8'h00, opcode driven to ALU during bubbles

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  decoded instruction present
in_ready  output  1  stage accepts instruction this cycle
in_opcode  input  C  ALU opcode
in_rd  input  R  destination register; 0 = no writeback
in_rs  input  R  source register for A
in_rt  input  R  source register for B (ignored when in_use_imm=1)
in_imm  input  N  immediate for B
in_use_imm  input  1  B = in_imm instead of RF[in_rt]
in_shift  input  S  shift amount
alu_opcode  output  C  registered opcode to ALU
alu_A  output  N  registered operand A
alu_B  output  N  registered operand B
alu_shift  output  S  registered shift to ALU
alu_Y  input  N  combinational ALU result
wb_valid  output  1  writeback performed at the last edge
wb_rd  output  R  register written
wb_data  output  N  value written
dbg_addr  input  R  debug read address
dbg_data  output  N  RF[dbg_addr], combinational, no bypass

Behaviour:
- Reset (async, rst=1): all RF entries 0; e_valid=0; alu_opcode=NOP_OP; alu_A, alu_B, alu_shift = 0; wb_valid=0, wb_rd=0, wb_data=0. An instruction in flight when rst asserts is discarded and no writeback occurs.
- Register 0 reads as 0. Writes to r0 are suppressed, and r0 never produces a hazard.
- Accept = in_valid & in_ready.
- Issue stage (E): on an accept edge, latch opcode/shift, A=RF[rs], B = in_use_imm ? in_imm : RF[rt], e_rd=in_rd, e_valid=1.
- Without an accept: e_valid=0, alu_opcode=NOP_OP, alu_A/alu_B/alu_shift hold their previous values.
- Writeback: at the edge ending a cycle with e_valid=1 and e_rd!=0, RF[e_rd] <= alu_Y, wb_valid=1, wb_rd=e_rd, wb_data=alu_Y. Otherwise wb_valid=0 and wb_rd/wb_data hold their values.
- Latency: accepted in cycle t; alu_* valid in t+1; RF updated and wb_* visible in t+2. Throughput is one instruction per cycle when there is no hazard.
- RF read in the accept cycle sees values written at prior edges only.
- Hazard: e_valid=1, e_rd!=0, and (in_rs==e_rd, or !in_use_imm & in_rt==e_rd).
- Without the optional feature, a hazard forces in_ready=0 for one cycle (the bubble). In the next cycle the writeback has landed and the instruction is accepted.
- With no hazard, in_ready=1. in_ready does not depend on in_valid beyond the hazard compare. No downstream backpressure exists.
- Simultaneous reads of the same register by rs and rt are both served. rd==rs (e.g. r3 = r3 + r3) is legal.
- Arithmetic: operands pass through unmodified. Saturation is the ALU's responsibility.

Optional Feature:
ALU_ISSUE_FWD_EN
- Defined: no hazard stall; in_ready is constant 1 after reset. On a hazard, the matching operand is taken from alu_Y, the in-flight result, instead of the RF. The immediate path is never forwarded.
- Undefined: stall behaviour as above.

Test Plan:
Bench ALU model: alu_Y = alu_A + alu_B.
- Reset mid-stream: issue r1=r0+imm 5, assert rst in the E cycle -> wb_valid stays 0, RF[1]=0, alu_opcode=NOP_OP, all outputs at reset values.
- Immediate load: r1 <- r0+imm 16'h0005 at t -> alu_A=0, alu_B=5 at t+1; wb_valid=1, wb_rd=1, wb_data=5 at t+2; dbg_data(r1)=5.
- Back-to-back dependent: r1<-imm 3, then r2<-r1+r1 (no FWD) -> in_ready=0 for exactly one cycle, then r2=6; with ALU_ISSUE_FWD_EN, in_ready stays 1 and r2=6 one cycle earlier.
- Independent stream: r1<-imm 1, r2<-imm 2, r3<-imm 3 on consecutive cycles -> in_ready always 1, three consecutive wb_valid pulses with values 1, 2, 3.
- r0 write: in_rd=0 with imm 16'h7FFF -> wb_valid=0, dbg_data(r0)=0. Then r1<-r0+r0, issued right after -> no stall, r1=0.
- Immediate ignores rt hazard: r4<-imm 9, then r5<-r4 (rs=0) with in_rt=4 and in_use_imm=1, imm 2 -> no stall, r5=2.
